// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - iterative RISC-V M-extension multiply/divide unit with tagged result handshake
module alu_muldiv #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_op1,
    input  logic [XLEN-1:0]  in_op2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_q, neg_d, rneg_q, rneg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [TAG_W-1:0]  tag_q, tag_d;

    logic              sgn1, sgn2, s1, s2, div_zero, div_ovf;
    logic [XLEN-1:0]   mag1, mag2, special;
    logic [XLEN:0]     mul_sum, div_top, div_diff;
    logic              div_ok;
    logic [2*XLEN-1:0] step, prod;
    logic [XLEN-1:0]   quo, rem, final_res;

    // Operand preparation for the request currently offered on the input port
    always_comb begin
        sgn1     = (in_op == 3'd1) || (in_op == 3'd2) || (in_op == 3'd4) || (in_op == 3'd6);
        sgn2     = (in_op == 3'd1) || (in_op == 3'd4) || (in_op == 3'd6);
        s1       = sgn1 && in_op1[XLEN-1];
        s2       = sgn2 && in_op2[XLEN-1];
        mag1     = s1 ? -in_op1 : in_op1;
        mag2     = s2 ? -in_op2 : in_op2;
        div_zero = (in_op2 == '0);
        div_ovf  = ((in_op == 3'd4) || (in_op == 3'd6)) &&
                   (in_op1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_op2 == '1);
        if (div_zero) begin
            special = in_op[1] ? in_op1 : '1;
        end else begin
            special = in_op[1] ? '0 : in_op1;
        end
    end

    // One iteration: acc holds {product_hi, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? b_q : '0)};
        div_top  = acc_q[2*XLEN-1:XLEN-1];
        div_diff = div_top - {1'b0, b_q};
        div_ok   = !div_diff[XLEN];
        if (op_q[2]) begin
            step = {(div_ok ? div_diff[XLEN-1:0] : div_top[XLEN-1:0]), acc_q[XLEN-2:0], div_ok};
        end else begin
            step = {mul_sum, acc_q[XLEN-1:1]};
        end
        prod = neg_q ? -step : step;
        quo  = step[XLEN-1:0];
        rem  = step[2*XLEN-1:XLEN];
        case (op_q)
            3'd0:          final_res = prod[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:          final_res = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:    final_res = neg_q ? -quo : quo;
            default:       final_res = rneg_q ? -rem : rem;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        b_d      = b_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        tag_d    = tag_q;
        case (state_q)
            IDLE: begin
                if (in_valid && !flush) begin
                    op_d   = in_op;
                    tag_d  = in_tag;
                    b_d    = mag2;
                    acc_d  = {{XLEN{1'b0}}, mag1};
                    neg_d  = s1 ^ s2;
                    rneg_d = s1;
                    cnt_d  = '0;
                    if (in_op[2] && (div_zero || div_ovf)) begin
                        result_d = special;
                        state_d  = DONE;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN-1)) begin
                    result_d = final_res;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            tag_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            tag_q    <= tag_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_result = result_q;
    assign out_tag    = tag_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - randomized and directed checks of alu_muldiv against an arithmetic reference model
module tb_alu_muldiv;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  in_op;
    logic [31:0] in_op1, in_op2, out_result;
    logic [4:0]  in_tag, out_tag;

    int n_tests = 0;
    int n_fail  = 0;

    alu_muldiv #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_op1(in_op1), .in_op2(in_op2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        int ia, ib;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = signed'(a);
        ib = signed'(b);
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0)) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one request and wait (bounded) for its result; lat counts cycles after the accept cycle
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, output logic [31:0] res, output logic [4:0] tg,
                         output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin step(); w++; end
        in_valid = 1'b1; in_op = op; in_op1 = a; in_op2 = b; in_tag = tag;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin step(); lat++; end
        res = out_result;
        tg  = out_tag;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        n_tests++;
        if ({in_ready, out_valid, out_result, out_tag} !== {1'b1, 1'b0, 32'd0, 5'd0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b res=%h tag=%h, want 1 0 0 0", in_ready, out_valid, out_result, out_tag);
        end
        rst = 1'b0;
        step();
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  ops  [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
        logic [31:0] as   [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                   32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs   [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                                   32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exps [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                   32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        int          lats [12] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};
        logic [31:0] res;
        logic [4:0]  tg;
        int          lat;
        for (int i = 0; i < 12; i++) begin
            do_op(ops[i], as[i], bs[i], 5'(9 + i), res, tg, lat);
            n_tests++;
            if (res !== exps[i] || tg !== 5'(9 + i) || lat != lats[i]) begin
                n_fail++;
                $display("FAIL directed_%0d op=%0d: got res=%h tag=%0d lat=%0d, want res=%h tag=%0d lat=%0d",
                         i, ops[i], res, tg, lat, exps[i], 5'(9 + i), lats[i]);
            end
            consume();
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b, res, exp_res;
        logic [4:0]  tag, tg;
        int          lat, exp_lat;
        for (int i = 0; i < 60; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            tag = 5'($urandom);
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'h8000_0000;
                default: ;
            endcase
            exp_res = ref_model(op, a, b);
            exp_lat = ref_latency(op, a, b);
            do_op(op, a, b, tag, res, tg, lat);
            n_tests++;
            if (res !== exp_res || tg !== tag || lat != exp_lat) begin
                n_fail++;
                $display("FAIL random_%0d op=%0d a=%h b=%h: got res=%h tag=%0d lat=%0d, want res=%h tag=%0d lat=%0d",
                         i, op, a, b, res, tg, lat, exp_res, tag, exp_lat);
            end
            repeat ($urandom_range(0, 3)) step();
            consume();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] res, exp_res;
        logic [4:0]  tg;
        int          lat;
        exp_res = ref_model(3'd4, 32'hFFFF_FC18, 32'd13);
        do_op(3'd4, 32'hFFFF_FC18, 32'd13, 5'd21, res, tg, lat);
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== exp_res || out_tag !== 5'd21) begin
                n_fail++;
                $display("FAIL backpressure_hold_%0d: got vld=%b rdy=%b res=%h tag=%0d, want 1 0 %h 21",
                         i, out_valid, in_ready, out_result, out_tag, exp_res);
            end
            step();
        end
        consume();
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_release: got rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    // Abort a running divide at iteration 10 with a competing request, by flush or by reset
    task automatic test_abort(input bit use_reset);
        logic [31:0] res;
        logic [4:0]  tg;
        int          lat, seen;
        in_valid = 1'b1; in_op = 3'd5; in_op1 = $urandom; in_op2 = 32'($urandom_range(1, 1000)); in_tag = 5'd17;
        step();
        in_valid = 1'b0;
        repeat (10) step();
        in_valid = 1'b1; in_op = 3'd0; in_op1 = 32'd5; in_op2 = 32'd5; in_tag = 5'd3;
        if (use_reset) rst = 1'b1; else flush = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_tag !== (use_reset ? 5'd0 : 5'd17) ||
            (use_reset && out_result !== 32'd0)) begin
            n_fail++;
            $display("FAIL abort_%0d_state: got rdy=%b vld=%b tag=%0d res=%h, want rdy=1 vld=0 tag=%0d",
                     use_reset, in_ready, out_valid, out_tag, out_result, use_reset ? 0 : 17);
        end
        seen = 0;
        repeat (40) begin step(); if (out_valid) seen++; end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL abort_%0d_no_valid: got out_valid high %0d cycles, want 0", use_reset, seen);
        end
        do_op(3'd0, 32'd3, 32'd4, 5'd6, res, tg, lat);
        n_tests++;
        if (res !== 32'd12 || tg !== 5'd6 || lat != 33) begin
            n_fail++;
            $display("FAIL abort_%0d_followup: got res=%h tag=%0d lat=%0d, want c 6 33", use_reset, res, tg, lat);
        end
        consume();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_op1 = '0; in_op2 = '0; in_tag = '0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_abort(1'b0);
        test_abort(1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
